benes4_unscramble_ser: RTL and testbench

- Receive-side companion of the 4-port Benes permutation network in the CNN datapath.
- Accepts one permuted 4-word vector (y1..y4) plus the 3-bit switch setting that produced it.
- Restores the original word order and streams the four words out serially, one per beat, over a valid/ready interface.
- Feeds the serial consumers (MAC/accumulator lanes) that sit downstream of the network.

---
 rtl/benes4_unscramble_ser.sv | 152 +++++++++++++++
 tb/tb_benes4_unscramble_ser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/benes4_unscramble_ser.sv
// Receive-side unscrambler for the 4-port Benes network: undoes the switch
// permutation on one captured vector and streams the words out x1..x4.
module benes4_unscramble_ser #(
    parameter int Q = 15,
    parameter int N = 32,
    parameter int m = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y1,
    input  logic [N-1:0] y2,
    input  logic [N-1:0] y3,
    input  logic [N-1:0] y4,
    input  logic [m-1:0] s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t       state_r;
    state_t       state_n;
    logic [N-1:0] word_buf_r [4];
    logic [N-1:0] word_buf_n [4];
    logic [N-1:0] y_s        [4];
    logic [1:0]   idx_r;
    logic [1:0]   idx_n;
    logic [1:0]   k_s;
    logic         accept_s;
    logic [N-1:0] out_data_r;
    logic [1:0]   out_idx_r;
    logic         out_last_r;
    logic         out_valid_r;
    logic         busy_r;

    // XOR mask applied to word indices by the forward network for setting sw.
    function automatic logic [1:0] perm_mask(input logic [2:0] sw);
        return {sw[1], sw[2] ^ sw[0]};
    endfunction

    // Handshake: a new vector may land in IDLE or on the final accepted beat.
    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            in_ready = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = (idx_r == 2'd3) && out_ready;
        end
    end

    assign accept_s = in_valid && in_ready;

    // Next-state, beat index and buffer load (inverse permutation at capture).
    always_comb begin
        y_s[0]  = y1;
        y_s[1]  = y2;
        y_s[2]  = y3;
        y_s[3]  = y4;
        k_s     = perm_mask(s[2:0]);
        state_n = state_r;
        idx_n   = idx_r;
        for (int i = 0; i < 4; i++) begin
            word_buf_n[i] = word_buf_r[i];
        end
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = DRAIN;
                    idx_n   = 2'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (!out_ready) begin
                    idx_n = idx_r;
                end else if (idx_r != 2'd3) begin
                    idx_n = idx_r + 2'd1;
                end else if (accept_s) begin
                    idx_n = 2'd0;
                end else begin
                    state_n = IDLE;
                    idx_n   = 2'd0;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 2'd0;
            end
        endcase
        if (accept_s) begin
            for (int i = 0; i < 4; i++) begin
                word_buf_n[i] = y_s[2'(i) ^ k_s];
            end
        end else begin
            idx_n = idx_n;
        end
    end

    // State, buffer and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            out_data_r  <= {N{1'b0}};
            out_idx_r   <= 2'd0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                word_buf_r[i] <= {N{1'b0}};
            end
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            for (int i = 0; i < 4; i++) begin
                word_buf_r[i] <= word_buf_n[i];
            end
            if (state_n == DRAIN) begin
                out_data_r  <= word_buf_n[idx_n];
                out_idx_r   <= idx_n;
                out_last_r  <= (idx_n == 2'd3);
                out_valid_r <= 1'b1;
                busy_r      <= 1'b1;
            end else begin
                out_data_r  <= {N{1'b0}};
                out_idx_r   <= 2'd0;
                out_last_r  <= 1'b0;
                out_valid_r <= 1'b0;
                busy_r      <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_benes4_unscramble_ser.sv
// Directed bench for benes4_unscramble_ser: inputs driven and outputs sampled
// on the falling edge, expected words taken from hand-built vectors.
module tb_benes4_unscramble_ser;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y1, y2, y3, y4;
    logic [2:0]  s;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_checks;
    int n_fail;

    localparam logic [31:0] X1 = 32'h0008_0000;
    localparam logic [31:0] X2 = 32'h0010_0000;
    localparam logic [31:0] X3 = 32'h0018_0000;
    localparam logic [31:0] X4 = 32'h0020_0000;

    logic [31:0] xv [4];
    logic [31:0] yv [8][4];

    benes4_unscramble_ser #(.Q(15), .N(32), .m(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .s(s),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] a, b, c, d, input logic [2:0] sv);
        in_valid = 1'b1;
        y1 = a; y2 = b; y3 = c; y4 = d; s = sv;
    endtask

    task automatic check_beat(input string tag, input int b);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, xv[b]);
        check({tag, "_idx"}, 32'(out_idx), 32'(b));
        check({tag, "_last"}, 32'(out_last), 32'(b == 3));
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle.
    task automatic run_vec(input string tag, input logic [31:0] a, b, c, d, input logic [2:0] sv);
        present(a, b, c, d, sv);
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        y1 = '0; y2 = '0; y3 = '0; y4 = '0; s = 3'b000;
        for (int bt = 0; bt < 4; bt++) begin
            check_beat(tag, bt);
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        xv[0] = X1; xv[1] = X2; xv[2] = X3; xv[3] = X4;
        // forward-permuted vectors, hand-listed per switch setting
        yv[0] = '{X1, X2, X3, X4};
        yv[1] = '{X2, X1, X4, X3};
        yv[2] = '{X3, X4, X1, X2};
        yv[3] = '{X4, X3, X2, X1};
        yv[4] = '{X2, X1, X4, X3};
        yv[5] = '{X1, X2, X3, X4};
        yv[6] = '{X4, X3, X2, X1};
        yv[7] = '{X3, X4, X1, X2};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        y1 = '0; y2 = '0; y3 = '0; y4 = '0; s = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_during", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        run_vec("s111", X3, X4, X1, X2, 3'b111);

        for (int k = 0; k < 8; k++) begin
            run_vec($sformatf("sweep%0d", k), yv[k][0], yv[k][1], yv[k][2], yv[k][3], 3'(k));
        end

        // backpressure at idx=1
        present(X2, X1, X4, X3, 3'b100);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        present(X4, X4, X4, X4, 3'b011);
        in_valid = 1'b0;
        check_beat("bp_b0", 0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_beat("bp_hold", 1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int bt = 1; bt < 4; bt++) begin
            check_beat("bp_resume", bt);
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_idle", 32'(out_valid), 32'd0);

        // back-to-back: second vector accepted on the last beat
        present(X1, X2, X3, X4, 3'b101);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int bt = 0; bt < 4; bt++) begin
            check_beat("b2b_first", bt);
            if (bt == 3) begin
                present(X2, X1, X4, X3, 3'b001);
                #1;
                check("b2b_in_ready", 32'(in_ready), 32'd1);
            end else begin
                #1;
                check("b2b_in_ready_mid", 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int bt = 0; bt < 4; bt++) begin
            check_beat("b2b_second", bt);
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_idle", 32'(out_valid), 32'd0);

        // reset mid-burst at idx=2
        present(X4, X3, X2, X1, 3'b110);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int bt = 0; bt < 2; bt++) begin
            check_beat("mid_pre", bt);
            @(posedge clk);
            @(negedge clk);
        end
        check_beat("mid_at2", 2);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_data", out_data, 32'd0);
        check("mid_out_idx", 32'(out_idx), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        run_vec("post_rst", X4, X3, X2, X1, 3'b011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
